router_pkt_tx: RTL
==================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 Parameter GAP_CYCLES, default 2: idle cycles held after the parity byte before the next request is accepted.
REQ-002 clock  input  1  single rising-edge clock.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  packet request strobe.
REQ-005 req_addr  input  2  destination port; 0..2 valid, 3 invalid.
REQ-006 req_len  input  6  payload byte count, 0..63.
REQ-007 req_ready  output  1  block idle and able to accept a request.
REQ-008 pl_data  input  8  payload byte from the producer.
REQ-009 pl_valid  input  1  pl_data valid.
REQ-010 pl_ready  output  1  block accepting payload bytes.
REQ-011 busy  input  1  router back-pressure; high means the current byte is not consumed.
REQ-012 data_out  output  8  byte to router data_in.
REQ-013 pkt_valid  output  1  to router pkt_valid; high for header and payload, low for parity.
REQ-014 done  output  1  one-cycle pulse when a packet completes.
REQ-015 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-016 Packet format SHALL be: header {req_len, req_addr}, then req_len payload bytes, then a parity byte equal to the XOR of the header and all payload bytes.
REQ-017 All outputs SHALL be registered, changing only on rising clock edges.
REQ-018 States SHALL be IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
REQ-019 IDLE: req_ready=1, pkt_valid=0, data_out=0; a request is accepted on an edge with req_valid=1 and req_ready=1.
REQ-020 Accepted request with req_addr=3 SHALL pulse err next cycle and remain in IDLE; no byte is driven.
REQ-021 Valid request SHALL latch addr/len and go to LOAD, or directly to HEADER when req_len=0.
REQ-022 LOAD: pl_ready=1; each edge with pl_valid=1 writes pl_data to the buffer and folds it into parity; after the req_len-th byte, pl_ready drops the next cycle and the state goes to HEADER.
REQ-023 HEADER: data_out=header, pkt_valid=1; held until an edge with busy=0, then PAYLOAD, or PARITY when req_len=0.
REQ-024 PAYLOAD: data_out=buffer byte in order, pkt_valid=1; advance only on edges with busy=0.
REQ-025 PAYLOAD SHALL present consecutive bytes on consecutive cycles when busy stays 0 (no bubbles), and SHALL never drop or repeat a byte under any busy pattern.
REQ-026 PAYLOAD SHALL go to PARITY after the last byte is consumed.
REQ-027 pkt_valid SHALL never deassert between header and last payload byte.
REQ-028 PARITY: data_out=parity, pkt_valid=0; held until an edge with busy=0, then GAP.
REQ-029 GAP: data_out=0, pkt_valid=0 for GAP_CYCLES cycles; done pulses on the final GAP cycle, then IDLE.
REQ-030 req_valid outside IDLE SHALL be ignored; pl_valid outside LOAD SHALL be ignored.
REQ-031 Buffer depth SHALL be 64 bytes; req_len=63 SHALL fill without wrap or overwrite.

Reset
REQ-032 resetn=0 SHALL immediately force: state IDLE, data_out=0, pkt_valid=0, req_ready=0 while asserted, pl_ready=0, done=0, err=0, parity=0, buffer pointers=0.
REQ-033 req_ready SHALL be 1 on the first edge after resetn deasserts.
REQ-034 Reset mid-packet SHALL abandon the packet; buffer contents need not be cleared.

Structure
REQ-035 Shared package router_pkg SHALL hold the address and length widths, ADDR_INVALID=2'd3, and the tx state enumeration.
REQ-036 Payload storage SHALL be one sub-module, router_pkt_buf (64x8, write/read pointers, synchronous write); the FSM and parity stay in router_pkt_tx.

Verification
REQ-037 req_len=10, req_addr=1, payload 0x01..0x0A, busy=0 -> header 0x29, payload 0x01..0x0A on consecutive cycles, parity 0x22 with pkt_valid=0, done pulse after 2 GAP cycles.
REQ-038 req_len=0, req_addr=2 -> header 0x02, then parity 0x02, then done; pl_ready never asserts.
REQ-039 Len=14 addr=0, busy high 3 cycles while payload byte 5 is driven -> byte 5 held 4 cycles, 14 unique bytes total, header 0x38, parity correct.
REQ-040 req_addr=3 -> err high exactly 1 cycle, pkt_valid stays 0, req_ready returns 1.
REQ-041 resetn pulsed low during PAYLOAD byte 3 -> data_out=0, pkt_valid=0 at once; a following len=1 addr=1 request yields header 0x05 and a correct parity.
REQ-042 req_len=63, addr=0, busy toggling every cycle -> header 0xFC, 63 bytes in order with no repeats, correct parity.

Source files
------------

// File: rtl/router_pkg.sv
// Shared widths, constants and tx state encoding
// for the router packet transmitter.
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 64;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } tx_state_t;

  function automatic logic [DATA_W-1:0] mk_header(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// 64x8 payload buffer with write/read pointers;
// the read port looks ahead so the reader sees no bubble.
module router_pkt_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [LEN_W-1:0]  wr_ptr,
  output logic [LEN_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [LEN_W-1:0] ONE = 1;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [LEN_W-1:0]  rd_ptr_nxt;

  assign rd_ptr_nxt = rd_en ? rd_ptr + ONE : rd_ptr;
  assign rd_data    = mem[rd_ptr_nxt];

  // storage array, written synchronously, never cleared
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // pointer registers, cleared at the start of each packet
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      rd_ptr <= rd_ptr_nxt;
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: loads payload, then sends
// header, payload and parity to the router.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              done,
  output logic              err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = 1;
  localparam logic [LEN_W-1:0] ONE      = 1;

  tx_state_t         state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [DATA_W-1:0] parity_q, parity_n;
  logic [GAP_W-1:0]  gap_q, gap_n;
  logic [DATA_W-1:0] data_n;
  logic              err_n, done_n;
  logic              wr_en, rd_en, clr;
  logic [LEN_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;

  router_pkt_buf u_buf (
    .clock   (clock),
    .resetn  (resetn),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_data (pl_data),
    .rd_en   (rd_en),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  // state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // next state, datapath updates and buffer strobes
  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    len_n    = len_q;
    parity_n = parity_q;
    gap_n    = gap_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    clr      = 1'b0;
    err_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          if (req_addr == ADDR_INVALID) begin
            err_n = 1'b1;
          end else begin
            addr_n   = req_addr;
            len_n    = req_len;
            parity_n = mk_header(req_len, req_addr);
            clr      = 1'b1;
            state_n  = (req_len == '0) ? S_HEADER : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (pl_valid) begin
          wr_en    = 1'b1;
          parity_n = parity_q ^ pl_data;
          if (wr_ptr == len_q - ONE) state_n = S_HEADER;
        end
      end
      S_HEADER: begin
        if (!busy) begin
          state_n = (len_q == '0) ? S_PARITY : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          if (rd_ptr == len_q - ONE) state_n = S_PARITY;
          else                       rd_en   = 1'b1;
        end
      end
      S_PARITY: begin
        if (!busy) begin
          state_n = S_GAP;
          gap_n   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_n = S_IDLE;
        else                   gap_n   = gap_q + GAP_ONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // output values for the cycle after this edge
  always_comb begin
    data_n = '0;
    done_n = (state_n == S_GAP) && (gap_n == GAP_LAST);
    unique case (state_n)
      S_HEADER:  data_n = mk_header(len_n, addr_n);
      S_PAYLOAD: data_n = rd_data;
      S_PARITY:  data_n = parity_n;
      default:   data_n = '0;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      len_q     <= '0;
      parity_q  <= '0;
      gap_q     <= '0;
      req_ready <= 1'b0;
      pl_ready  <= 1'b0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      addr_q    <= addr_n;
      len_q     <= len_n;
      parity_q  <= parity_n;
      gap_q     <= gap_n;
      req_ready <= (state_n == S_IDLE);
      pl_ready  <= (state_n == S_LOAD);
      data_out  <= data_n;
      pkt_valid <= (state_n == S_HEADER) || (state_n == S_PAYLOAD);
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule
